gpio_port: RTL
==============

# gpio_port

Memory-mapped 8-bit general-purpose I/O port hanging directly off the CPU data and address buses as a bus slave. The port decodes four byte registers: direction, output latch, synchronized pin state, and edge-capture flags. It drives or releases its external pins per bit and raises an interrupt request on input edges. Instances serve PORTA..PORTD. PORTA is decoded at 0x8000–0x8003 by external chip-select logic (`address_bus[15]` set and `address_bus[14:2]` all zero).

## Interface
- `WIDTH`, 8, data and pin width
- `ARM_CYCLES`, 3, cycles after reset release before edge capture is enabled (range 1–3)

- `clk`  in  1  system clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `address`  in  2  register select, `address_bus[1:0]`
- `data`  inout  WIDTH  CPU data bus
- `CS`  in  1  chip select from external address decode
- `WE`  in  1  write enable from the SID decoder
- `OE`  in  1  output enable from the MID decoder
- `gpio`  inout  WIDTH  external pins
- `irq`  out  1  level interrupt request, high while any enabled flag is set

## Operation
- Register map:
  - 0 DDR: bit = 1 makes the pin an output. Reset 0x00.
  - 1 OUT: output latch. Reset 0x00.
  - 2 PIN: read-only 2-flop synchronized pin values. Writes are ignored.
  - 3 IFLG: edge flags. Write-1-to-clear; written zeros leave bits unchanged.
- Write: on the rising `clk` edge with `CS & WE`, the addressed register updates.
- Read: `data` is driven combinationally with the addressed register when `CS & OE & ~WE`. Otherwise `data` is high-Z. `WE & OE` together is treated as a write, with no drive.
- Pins: `gpio[i]` = `OUT[i]` when `DDR[i]`, else high-Z. PIN reflects the pad in either direction, so output bits read back their driven value.
- Edge capture: `prev` holds PIN delayed by one cycle. IFLG bit i sets when `PIN[i] != prev[i]`, `DDR[i] == 0`, and capture is armed.
- Arming: a 2-bit counter clears on reset and counts up to `ARM_CYCLES`. Capture is enabled only once the count saturates. This suppresses spurious flags while the synchronizer fills.
- Simultaneous set and clear of the same IFLG bit in one cycle: set wins.
- `irq` = OR of IFLG, registered (one flop after IFLG).
- Reset mid-operation clears DDR, OUT, IFLG, the synchronizer, `prev`, the arm counter, and `irq` on the next rising edge. Pins release to high-Z combinationally, since DDR becomes 0.

## Timing
- Reset values: `data` Z, `gpio` all Z, `irq` 0, all registers 0.
- Write to OUT/DDR: the pin changes in the same cycle the register updates (after edge N).
- Pad to PIN latency: 2 cycles.
- Pad edge to IFLG set: 3 cycles (2 sync + 1 compare).
- IFLG to `irq`: 1 more cycle.
- A read of IFLG in the same cycle a flag sets returns the old value.
- The write-1-to-clear takes effect at edge N; `irq` falls at edge N+1 if no flags remain set.
- Reads have zero latency and are combinational from `address`, `CS`, `OE`, and `WE`.

## Structure
- Register offset constants belong in the shared defines file alongside the `CB_*` and opcode macros: `PORT_REG_DDR` 0, `PORT_REG_OUT` 1, `PORT_REG_PIN` 2, `PORT_REG_IFLG` 3.
- One sub-module, `sync_edge_det`, parameterized by WIDTH. It contains the 2-flop synchronizer, the `prev` register, and the change mask output.
- Top level holds register decode, tri-state drivers, the arm counter, IFLG, and `irq`.

## Test plan
- Reset: assert `reset` for 1 cycle with `gpio` externally pulled to 0xFF and held → `gpio` stays Z, reads of all four registers return 0x00, and IFLG stays 0x00 for the whole arming window.
- Direction/output: write DDR=0x0F then OUT=0xA5 → `gpio[3:0]`=0x5 and `gpio[7:4]`=Z. After 2 cycles, PIN reads 0x_5 with the upper nibble following the external drive.
- Edge capture: DDR=0x00, external pin 2 toggles 0→1 → IFLG=0x04 at edge +3 and `irq`=1 at edge +4. Write IFLG=0x04 → IFLG=0x00 and `irq`=0 one cycle later.
- W1C selectivity and collision: IFLG=0x05, write 0x01 → 0x04. Write 0x04 in the same cycle as a new edge on pin 2 → bit 2 remains set.
- Bus rules: `CS=0` with OE=1 → `data` Z. `WE=OE=1` on address 1 with 0x3C → OUT=0x3C and `data` never driven. A write to PIN leaves PIN unchanged.
- Output pins ignored for capture: DDR=0xFF, toggle OUT every cycle → IFLG stays 0x00.

Source files
------------

// File: rtl/gpio_port_pkg.sv
// Shared definitions for the gpio_port bus slave: register offsets and the
// arm-counter limit helper.
package gpio_port_pkg;

  typedef enum logic [1:0] {
    PORT_REG_DDR  = 2'd0,
    PORT_REG_OUT  = 2'd1,
    PORT_REG_PIN  = 2'd2,
    PORT_REG_IFLG = 2'd3
  } port_reg_e;

  // The arm counter is two bits wide, so the usable window is 1..3 cycles.
  function automatic logic [1:0] arm_limit(input int arm_cycles);
    int clamped;
    clamped = (arm_cycles < 1) ? 1 : ((arm_cycles > 3) ? 3 : arm_cycles);
    return clamped[1:0];
  endfunction

endpackage

// File: rtl/gpio_port_sync_edge_det.sv
// Two-flop pad synchronizer plus a one-cycle delayed copy, producing the
// synchronized pin value and a per-bit change mask.
module sync_edge_det #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pin_o,
  output logic [WIDTH-1:0] change_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= pad_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pin_o    = sync_q;
  assign change_o = sync_q ^ prev_q;

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO port: DDR/OUT/PIN/IFLG registers, per-bit tri-state pins
// and a registered edge interrupt.
module gpio_port
  import gpio_port_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ARM_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  inout  wire  [WIDTH-1:0] data,
  input  logic             CS,
  input  logic             WE,
  input  logic             OE,
  inout  wire  [WIDTH-1:0] gpio,
  output logic             irq
);

  localparam logic [1:0] ARM_LIMIT = arm_limit(ARM_CYCLES);

  logic [WIDTH-1:0] ddr_q, ddr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] iflg_q, iflg_d;
  logic [1:0]       arm_q, arm_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] pin_sync;
  logic [WIDTH-1:0] pin_change;
  logic [WIDTH-1:0] set_mask;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] rd_data;
  logic             wr_en;
  logic             rd_en;
  logic             armed;

  sync_edge_det #(.WIDTH(WIDTH)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .pad_i    (gpio),
    .pin_o    (pin_sync),
    .change_o (pin_change)
  );

  // A simultaneous WE and OE is a write; the bus is never driven then.
  assign wr_en = CS & WE;
  assign rd_en = CS & OE & ~WE;

  assign armed    = (arm_q == ARM_LIMIT);
  assign set_mask = pin_change & ~ddr_q & {WIDTH{armed}};

  always_comb begin
    ddr_d    = ddr_q;
    out_d    = out_q;
    clr_mask = '0;
    if (wr_en) begin
      case (port_reg_e'(address))
        PORT_REG_DDR:  ddr_d    = data;
        PORT_REG_OUT:  out_d    = data;
        PORT_REG_IFLG: clr_mask = data;
        default:       ;
      endcase
    end
    // A new edge outranks a clear landing on the same bit.
    iflg_d = (iflg_q & ~clr_mask) | set_mask;
    arm_d  = armed ? arm_q : arm_q + 2'd1;
    irq_d  = |iflg_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ddr_q  <= '0;
      out_q  <= '0;
      iflg_q <= '0;
      arm_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      ddr_q  <= ddr_d;
      out_q  <= out_d;
      iflg_q <= iflg_d;
      arm_q  <= arm_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (port_reg_e'(address))
      PORT_REG_DDR:  rd_data = ddr_q;
      PORT_REG_OUT:  rd_data = out_q;
      PORT_REG_PIN:  rd_data = pin_sync;
      PORT_REG_IFLG: rd_data = iflg_q;
      default:       rd_data = '0;
    endcase
  end

  assign data = rd_en ? rd_data : {WIDTH{1'bz}};

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pad
    assign gpio[gi] = ddr_q[gi] ? out_q[gi] : 1'bz;
  end

  assign irq = irq_q;

endmodule
